// File: rtl/fifo_ram_pkg.sv
// Shared types and defaults for the RAM-backed FIFO controller.
// Optional flush port is enabled with FIFO_FLUSH_EN.
package fifo_ram_pkg;

  localparam int DEF_LEN_DATA = 32;
  localparam int DEF_RAM_SIZE = 512;

  typedef enum logic {
    O_EMPTY = 1'b0,
    O_VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller driving an external simple dual-port RAM with 1-cycle reads.
// Define FIFO_FLUSH_EN to add a synchronous flush input.
module fifo_ram_ctrl
  import fifo_ram_pkg::*;
#(
  parameter int LEN_DATA = DEF_LEN_DATA,
  parameter int RAM_SIZE = DEF_RAM_SIZE,
  localparam int LEN_ADDR = $clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
`ifdef FIFO_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LEN_DATA-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] out_data,
  output logic                ram_ena,
  output logic                ram_wea,
  output logic [LEN_ADDR-1:0] ram_addra,
  output logic [LEN_DATA-1:0] ram_dina,
  output logic                ram_enb,
  output logic [LEN_ADDR-1:0] ram_addrb,
  input  logic [LEN_DATA-1:0] ram_doutb
);

  localparam logic [LEN_ADDR:0] CNT_FULL =
    (LEN_ADDR+1)'(RAM_SIZE);

  logic [LEN_ADDR-1:0] wr_ptr;
  logic [LEN_ADDR-1:0] rd_ptr;
  logic [LEN_ADDR:0]   ram_cnt;
  out_state_t          state;
  out_state_t          state_nxt;
  logic                clr;
  logic                push;
  logic                rd_avail;
  logic                rd_issue;

`ifdef FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign in_ready = (ram_cnt != CNT_FULL);
  assign push     = in_valid && in_ready && !clr;

  // ram_cnt excludes this cycle's write, so a read never hits it
  assign rd_avail = (ram_cnt != '0);
  assign rd_issue = rd_avail && !clr &&
                    ((state == O_EMPTY) || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !rd_issue)
        ram_cnt <= ram_cnt + 1'b1;
      else if (!push && rd_issue)
        ram_cnt <= ram_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= O_EMPTY;
    else if (clr)
      state <= O_EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    priority case (1'b1)
      rd_issue:
        state_nxt = O_VALID;
      (state == O_EMPTY) || out_ready:
        state_nxt = O_EMPTY;
      default: ;
    endcase
  end

  always_comb begin
    out_valid = (state == O_VALID);
    out_data  = ram_doutb;
    ram_ena   = push;
    ram_wea   = push;
    ram_addra = wr_ptr;
    ram_dina  = in_data;
    ram_enb   = rd_issue;
    ram_addrb = rd_ptr;
  end

endmodule
